lsu_align_ctrl: RTL and testbench

// Load/store alignment controller between the EX/MEM pipeline register and the data memory.

---
 rtl/lsu_align_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lsu_align_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_align_ctrl.sv
// lsu_align_ctrl: turns one byte/half/word load or store into one or two
// word-aligned memory accesses. Stores are lane-positioned with byte enables.
// Loads are merged across the word boundary, then sign- or zero-extended.
module lsu_align_ctrl #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wd,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [3:0]            mem_be,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    load_q, load_d;
  logic                    err_q, err_d;
  logic [2:0]              f3_q, f3_d;
  logic [1:0]              off_q, off_d;
  logic [7:0]              mask_q, mask_d;
  logic [2*DATA_W-1:0]     wdata_q, wdata_d;
  logic [DM_ADDRESS-1:0]   word0_q, word0_d;
  logic [DATA_W-1:0]       w0_q, w0_d;
  logic [DATA_W-1:0]       w1_q, w1_d;

  logic                    split;
  logic                    accept;
  logic [3:0]              req_lanes;
  logic                    req_err;
  logic [2*DATA_W-1:0]     merged;
  logic [DM_ADDRESS-1:0]   word1;

  // Request decode: lane footprint of the access and legality.
  always_comb begin
    case (Funct3[1:0])
      2'd0:    req_lanes = 4'b0001;
      2'd1:    req_lanes = 4'b0011;
      default: req_lanes = 4'b1111;
    endcase
    req_err = (MemRead && MemWrite)
           || (MemRead && ((Funct3 == 3'd3) || (Funct3[2:1] == 2'b11)))
           || (MemWrite && (Funct3 > 3'd2));
  end

  assign split  = |mask_q[7:4];
  assign word1  = word0_q + DM_ADDRESS'(4);
  assign accept = req_valid && req_ready && (MemRead || MemWrite);
  assign merged = {w1_q, w0_q} >> {off_q, 3'b000};

  // State and latched request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      mask_q  <= 8'd0;
      wdata_q <= '0;
      word0_q <= '0;
      w0_q    <= '0;
      w1_q    <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
      err_q   <= err_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      word0_q <= word0_d;
      w0_q    <= w0_d;
      w1_q    <= w1_d;
    end
  end

  // Next-state, data capture and all outputs.
  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    err_d      = err_q;
    f3_d       = f3_q;
    off_d      = off_q;
    mask_d     = mask_q;
    wdata_d    = wdata_q;
    word0_d    = word0_q;
    w0_d       = w0_q;
    w1_d       = w1_q;
    req_ready  = (state_q == IDLE) && !reset;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    mem_addr   = word0_q;
    mem_wdata  = wdata_q[DATA_W-1:0];
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load_d  = MemRead;
          err_d   = req_err;
          f3_d    = Funct3;
          off_d   = addr[1:0];
          mask_d  = {4'b0000, req_lanes} << addr[1:0];
          wdata_d = {{DATA_W{1'b0}}, wd} << {addr[1:0], 3'b000};
          word0_d = {addr[DM_ADDRESS-1:2], 2'b00};
          w0_d    = '0;
          w1_d    = '0;
          state_d = req_err ? RESP : ACC0;
        end
      end
      ACC0: begin
        mem_re  = load_q;
        mem_we  = !load_q;
        mem_be  = load_q ? 4'b0000 : mask_q[3:0];
        state_d = split ? ACC1 : (load_q ? CAP : RESP);
      end
      ACC1: begin
        mem_re    = load_q;
        mem_we    = !load_q;
        mem_be    = load_q ? 4'b0000 : mask_q[7:4];
        mem_addr  = word1;
        mem_wdata = wdata_q[2*DATA_W-1:DATA_W];
        // word0 read issued in ACC0 arrives now
        if (load_q) w0_d = mem_rdata;
        state_d = load_q ? CAP : RESP;
      end
      CAP: begin
        if (split) w1_d = mem_rdata;
        else       w0_d = mem_rdata;
        state_d = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        if (load_q && !err_q) begin
          case (f3_q)
            3'd0:    resp_rdata = {{(DATA_W-8){merged[7]}}, merged[7:0]};
            3'd1:    resp_rdata = {{(DATA_W-16){merged[15]}}, merged[15:0]};
            3'd4:    resp_rdata = {{(DATA_W-8){1'b0}}, merged[7:0]};
            3'd5:    resp_rdata = {{(DATA_W-16){1'b0}}, merged[15:0]};
            default: resp_rdata = merged[DATA_W-1:0];
          endcase
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// tb_lsu_align_ctrl: directed plus random requests against a byte-addressed
// reference memory model; DUT memory side is a word memory with one-cycle read.
module tb_lsu_align_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  Funct3;
  logic [8:0]  addr;
  logic [31:0] wd;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [8:0]  mem_addr;
  logic        mem_re;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mem_b [512];
  logic [7:0] ref_b [512];

  lsu_align_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .Funct3(Funct3), .addr(addr), .wd(wd),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word-wide data memory seen by the DUT
  always @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) mem_b[int'(mem_addr) + i] = mem_wdata[8*i +: 8];
    if (mem_re)
      mem_rdata <= {mem_b[int'(mem_addr) + 3], mem_b[int'(mem_addr) + 2],
                    mem_b[int'(mem_addr) + 1], mem_b[int'(mem_addr)]};
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_word(input int a, input logic [31:0] v);
    for (int i = 0; i < 4; i++) begin
      mem_b[a + i] = v[8*i +: 8];
      ref_b[a + i] = v[8*i +: 8];
    end
  endtask

  // One request, checked against the byte-level model
  task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [8:0] a, input logic [31:0] d, input string tag,
                        output logic [31:0] r_data);
    logic        err, split, got, bad, r_err;
    logic [31:0] raw, exp_rd;
    int          n, lat_exp, nre_exp, nwe_exp, cyc, nre, nwe, idx;

    err   = (rd && wr) || (rd && (f3 == 3 || f3 == 6 || f3 == 7)) || (wr && f3 > 2);
    n     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    split = (int'(a[1:0]) + n) > 4;
    exp_rd = 32'd0; nre_exp = 0; nwe_exp = 0;
    if (err) lat_exp = 1;
    else if (rd) begin
      raw = 32'd0;
      for (int i = 0; i < n; i++) raw |= 32'(ref_b[(int'(a) + i) % 512]) << (8*i);
      case (f3)
        3'd0:    exp_rd = 32'(signed'(raw[7:0]));
        3'd1:    exp_rd = 32'(signed'(raw[15:0]));
        default: exp_rd = raw;
      endcase
      lat_exp = split ? 4 : 3;
      nre_exp = split ? 2 : 1;
    end else begin
      lat_exp = split ? 3 : 2;
      nwe_exp = split ? 2 : 1;
      for (int i = 0; i < n; i++) ref_b[(int'(a) + i) % 512] = d[8*i +: 8];
    end

    @(negedge clk);
    check({tag, " ready"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; MemRead = rd; MemWrite = wr; Funct3 = f3; addr = a; wd = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    MemRead = 1'($urandom); MemWrite = 1'($urandom); Funct3 = 3'($urandom);
    addr = 9'($urandom); wd = $urandom;

    cyc = 0; nre = 0; nwe = 0; got = 1'b0; bad = 1'b0; r_err = 1'b0; r_data = 32'hx;
    while (!got && cyc < 12) begin
      @(negedge clk);
      cyc++;
      if (mem_re) nre++;
      if (mem_we) nwe++;
      if (mem_re && mem_we) bad = 1'b1;
      if (!mem_we && mem_be != 4'b0000) bad = 1'b1;
      if (resp_valid) begin
        got = 1'b1; r_err = resp_err; r_data = resp_rdata;
      end
    end
    check({tag, " latency"}, 64'(got ? cyc : -1), 64'(lat_exp));
    check({tag, " err"},     64'(r_err),  64'(err));
    check({tag, " rdata"},   64'(r_data), 64'(exp_rd));
    check({tag, " reads"},   64'(nre),    64'(nre_exp));
    check({tag, " writes"},  64'(nwe),    64'(nwe_exp));
    check({tag, " strobes"}, 64'(bad),    64'd0);
    if (wr && !err)
      for (int i = 0; i < n; i++) begin
        idx = (int'(a) + i) % 512;
        check({tag, " membyte"}, 64'(mem_b[idx]), 64'(ref_b[idx]));
      end
    $display("[TB] %s rd=%0b wr=%0b f3=%0d addr=%03h wd=%08h -> lat=%0d err=%0b rdata=%08h",
             tag, rd, wr, f3, a, d, cyc, r_err, r_data);
  endtask

  initial begin
    logic [31:0] rdat;
    int          sel, mism;
    logic        rd, wr;

    reset = 1'b1; req_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
    Funct3 = 3'd0; addr = 9'd0; wd = 32'd0;
    for (int i = 0; i < 512; i++) begin
      mem_b[i] = 8'($urandom);
      ref_b[i] = mem_b[i];
    end
    repeat (3) @(negedge clk);
    check("reset ready", 64'(req_ready),  64'd0);
    check("reset valid", 64'(resp_valid), 64'd0);
    check("reset err",   64'(resp_err),   64'd0);
    check("reset re",    64'(mem_re),     64'd0);
    check("reset we",    64'(mem_we),     64'd0);
    check("reset be",    64'(mem_be),     64'd0);
    reset = 1'b0;
    #1;
    check("release ready", 64'(req_ready), 64'd1);

    // Byte loads with sign and zero extension
    set_word(32'h10, 32'h80FF_0000);
    do_req(1, 0, 3'd0, 9'h013, 32'd0, "t2_lb", rdat);
    check("t2 lb value", 64'(rdat), 64'hFFFF_FF80);
    do_req(1, 0, 3'd4, 9'h013, 32'd0, "t2_lbu", rdat);
    check("t2 lbu value", 64'(rdat), 64'h0000_0080);

    // Aligned word store, then read it back
    do_req(0, 1, 3'd2, 9'h010, 32'hDEAD_BEEF, "t1_sw", rdat);
    do_req(1, 0, 3'd2, 9'h010, 32'd0, "t1_lw", rdat);
    check("t1 readback", 64'(rdat), 64'hDEAD_BEEF);

    // Split halfword store
    do_req(0, 1, 3'd1, 9'h00B, 32'h0000_1234, "t3_sh", rdat);
    check("t3 byte0b", 64'(mem_b[11]), 64'h34);
    check("t3 byte0c", 64'(mem_b[12]), 64'h12);

    // Split word load wrapping from the top of memory to address 0
    set_word(32'h1FC, 32'hAABB_CCDD);
    set_word(32'h000, 32'h1122_3344);
    do_req(1, 0, 3'd2, 9'h1FE, 32'd0, "t4_lw_wrap", rdat);
    check("t4 value", 64'(rdat), 64'h3344_AABB);

    // Illegal requests
    do_req(1, 1, 3'd2, 9'h020, 32'h5555_AAAA, "t5_rdwr", rdat);
    do_req(1, 0, 3'd3, 9'h020, 32'd0, "t5_lw_f3", rdat);
    do_req(0, 1, 3'd4, 9'h020, 32'h1, "t5_sw_f3", rdat);

    // req_valid without a memory operation is ignored
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'd2; addr = 9'h040;
    repeat (3) begin
      @(negedge clk);
      check("noop activity", 64'({mem_re, mem_we, resp_valid}), 64'd0);
      check("noop ready",    64'(req_ready), 64'd1);
    end
    req_valid = 1'b0;

    // Reset during the second access of a split store
    @(negedge clk);
    req_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; Funct3 = 3'd1; addr = 9'h0AB; wd = 32'h0000_5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("t6 acc0 we", 64'(mem_we), 64'd1);
    @(negedge clk);
    check("t6 acc1 addr", 64'(mem_addr), 64'h0AC);
    ref_b[9'h0AB] = 8'h78;
    reset = 1'b1;
    #1;
    check("t6 rst we",    64'(mem_we),     64'd0);
    check("t6 rst be",    64'(mem_be),     64'd0);
    check("t6 rst ready", 64'(req_ready),  64'd0);
    check("t6 rst valid", 64'(resp_valid), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6 ready",  64'(req_ready),     64'd1);
    check("t6 byte0",  64'(mem_b[9'h0AB]), 64'h78);
    check("t6 byte1",  64'(mem_b[9'h0AC]), 64'(ref_b[9'h0AC]));
    $display("[TB] t6 reset in ACC1: byte0=%02h byte1=%02h", mem_b[9'h0AB], mem_b[9'h0AC]);
    do_req(1, 0, 3'd2, 9'h0A8, 32'd0, "t6_lw_after", rdat);

    // Random traffic
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 9);
      rd  = (sel <= 4) || (sel == 9);
      wr  = (sel >= 5);
      do_req(rd, wr, 3'($urandom_range(0, 7)), 9'($urandom), $urandom, "rand", rdat);
    end

    mism = 0;
    for (int i = 0; i < 512; i++) if (mem_b[i] !== ref_b[i]) mism++;
    check("final memory", 64'(mism), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
